xf100_ifu_ir_fifo: RTL

XF100_IFU_IR_FIFO -- requirements
Module: xf100_ifu_ir_fifo

---
 rtl/xf100_ifu_ir_fifo.sv | 128 ++++++++++++
 1 files changed

// File: rtl/xf100_ifu_ir_fifo.sv
// xf100_ifu_ir_fifo: instruction buffer between fetch and decode, DEPTH 2 or 4 entries.
// Optional zero-latency fetch-to-decode bypass when XF100_IR_BYPASS_EN is defined.
`ifndef XF100_INSTR_SIZE
`define XF100_INSTR_SIZE 32
`endif
`ifndef XF100_XLEN
`define XF100_XLEN 32
`endif

module xf100_ifu_ir_fifo #(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         ifu_i_valid,
    output logic                         ifu_o_ready,
    input  logic [`XF100_INSTR_SIZE-1:0] ifu_i_instr,
    input  logic [`XF100_XLEN-1:0]       ifu_i_pc,
    input  logic                         ifu_i_err,
    output logic                         ir_o_valid,
    input  logic                         ir_i_ready,
    output logic [`XF100_INSTR_SIZE-1:0] ir_o_instr,
    output logic [`XF100_XLEN-1:0]       ir_o_pc,
    output logic                         ir_o_err,
    input  logic                         ir_i_flush,
    output logic [$clog2(DEPTH):0]       ir_o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int INS_W = `XF100_INSTR_SIZE;
    localparam int PC_W  = `XF100_XLEN;
    localparam int ENT_W = INS_W + PC_W + 1;
    localparam logic [INS_W-1:0] NOP_INSTR = INS_W'(32'h0000_0013);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    logic [ENT_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;

    logic             not_full_s;
    logic             push_s;
    logic             pop_s;
    logic             bypass_s;
    logic             wr_en_s;
    logic             rd_adv_s;
    logic [ENT_W-1:0] head_s;
    logic [ENT_W-1:0] in_ent_s;

    assign ir_o_count = count_r;
    assign in_ent_s   = {ifu_i_instr, ifu_i_pc, ifu_i_err};

    // Handshake qualification, bypass selection and head presentation.
    always_comb begin
        not_full_s  = (count_r < DEPTH_CNT);
        // rst_n gating keeps ready low for the whole reset window, not just after an edge
        ifu_o_ready = rst_n & not_full_s & ~ir_i_flush;
        push_s      = ifu_i_valid & ifu_o_ready;
        head_s      = mem_r[rd_ptr_r];
`ifdef XF100_IR_BYPASS_EN
        bypass_s    = rst_n & (count_r == CNT_W'(0)) & ifu_i_valid & ~ir_i_flush;
        ir_o_valid  = (count_r != CNT_W'(0)) | bypass_s;
        if (bypass_s) begin
            ir_o_instr = ifu_i_instr;
            ir_o_pc    = ifu_i_pc;
            ir_o_err   = ifu_i_err;
        end else if (count_r != CNT_W'(0)) begin
            {ir_o_instr, ir_o_pc, ir_o_err} = head_s;
        end else begin
            ir_o_instr = NOP_INSTR;
            ir_o_pc    = PC_W'(0);
            ir_o_err   = 1'b0;
        end
`else
        bypass_s    = 1'b0;
        ir_o_valid  = (count_r != CNT_W'(0));
        if (ir_o_valid) begin
            {ir_o_instr, ir_o_pc, ir_o_err} = head_s;
        end else begin
            ir_o_instr = NOP_INSTR;
            ir_o_pc    = PC_W'(0);
            ir_o_err   = 1'b0;
        end
`endif
        pop_s    = ir_o_valid & ir_i_ready;
        // A bypassed word that decode takes immediately never touches storage
        wr_en_s  = push_s & ~(bypass_s & ir_i_ready);
        rd_adv_s = pop_s & ~bypass_s;
    end

    // Occupancy and pointer state; flush overrides any handshake in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= PTR_W'(0);
            rd_ptr_r <= PTR_W'(0);
            count_r  <= CNT_W'(0);
        end else if (ir_i_flush) begin
            wr_ptr_r <= PTR_W'(0);
            rd_ptr_r <= PTR_W'(0);
            count_r  <= CNT_W'(0);
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (rd_adv_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({wr_en_s, rd_adv_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry payload storage; validity is carried entirely by count_r.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= in_ent_s;
        end
    end

endmodule
